// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: access-size encoding, memory depth default, size decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mem_stage_pkg;

  // 256 words of data memory by default (1 KiB byte address space)
  localparam int NB_ADDR_DEFAULT = 8;

  typedef enum logic [1:0] {
    SIZE_NONE = 2'd0,
    SIZE_BYTE = 2'd1,
    SIZE_HALF = 2'd2,
    SIZE_WORD = 2'd3
  } mem_size_e;

  // Word wins over halfword, halfword over byte; no enable means no access
  function automatic mem_size_e decode_size(input logic word_en,
                                            input logic half_en,
                                            input logic byte_en);
    if (word_en)      return SIZE_WORD;
    else if (half_en) return SIZE_HALF;
    else if (byte_en) return SIZE_BYTE;
    else              return SIZE_NONE;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-organised data memory with per-byte write enables, one read port and one debug port.
// Latency: reads combinational from current contents; writes commit at the rising edge.
// Backpressure: none; the caller gates i_we.
module data_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [NB_ADDR-1:0]   i_addr,
  input  logic [NB_DATA/8-1:0] i_be,
  input  logic [NB_DATA-1:0]   i_wdata,
  output logic [NB_DATA-1:0]   o_rdata,
  input  logic [NB_ADDR-1:0]   i_debug_addr,
  output logic [NB_DATA-1:0]   o_debug_data
);

  localparam int NB_BE = NB_DATA / 8;

  // Contents deliberately have no reset
  logic [NB_DATA-1:0] r_mem [0:(1 << NB_ADDR)-1];

  // Byte-lane write: only lanes with i_be set are updated, others keep their value
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < NB_BE; l++) begin
        if (i_be[l]) r_mem[i_addr][l*8 +: 8] <= i_wdata[l*8 +: 8];
      end
    end
  end

  assign o_rdata      = r_mem[i_addr];
  assign o_debug_data = r_mem[i_debug_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolve, sized load/store to data memory, MEM/WB register.
// Latency: pc_src/branch_addr/fwd_data combinational; WB outputs 1 cycle after an enabled edge.
// Backpressure: i_MEM_enable low holds the MEM/WB register and blocks stores.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_PC   = 32,
  parameter int NB_REG  = 5,
  parameter int NB_ADDR = NB_ADDR_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_MEM_enable,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic               i_MEM_mem_read,
  input  logic               i_MEM_mem_write,
  input  logic               i_MEM_branch,
  input  logic               i_MEM_zero,
  input  logic [NB_PC-1:0]   i_MEM_branch_addr,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_DATA-1:0] i_MEM_data_b,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  input  logic               i_MEM_byte_en,
  input  logic               i_MEM_halfword_en,
  input  logic               i_MEM_word_en,
  input  logic               i_MEM_unsigned,
  input  logic               i_MEM_r31_ctrl,
  input  logic [NB_PC-1:0]   i_MEM_pc,
  input  logic               i_MEM_hlt,
  input  logic [NB_ADDR-1:0] i_MEM_debug_addr,
  output logic               o_MEM_pc_src,
  output logic [NB_PC-1:0]   o_MEM_branch_addr,
  output logic [NB_DATA-1:0] o_MEM_fwd_data,
  output logic               o_WB_reg_write,
  output logic               o_WB_mem_to_reg,
  output logic               o_WB_r31_ctrl,
  output logic               o_WB_hlt,
  output logic [NB_DATA-1:0] o_WB_mem_data,
  output logic [NB_DATA-1:0] o_WB_alu_result,
  output logic [NB_REG-1:0]  o_WB_selected_reg,
  output logic [NB_PC-1:0]   o_WB_pc,
  output logic [NB_DATA-1:0] o_MEM_debug_data
);

  localparam int NB_BE = NB_DATA / 8;

  mem_size_e            w_size;
  logic [NB_ADDR-1:0]   w_word_idx;
  logic                 w_we;
  logic [NB_BE-1:0]     w_be;
  logic [NB_DATA-1:0]   w_wdata;
  logic [NB_DATA-1:0]   w_rd_word;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [NB_DATA-1:0]   w_load;

  logic                 r_reg_write;
  logic                 r_mem_to_reg;
  logic                 r_r31_ctrl;
  logic                 r_hlt;
  logic [NB_DATA-1:0]   r_mem_data;
  logic [NB_DATA-1:0]   r_alu_result;
  logic [NB_REG-1:0]    r_selected_reg;
  logic [NB_PC-1:0]     r_pc;

  assign o_MEM_pc_src      = i_MEM_branch & i_MEM_zero;
  assign o_MEM_branch_addr = i_MEM_branch_addr;
  assign o_MEM_fwd_data    = i_MEM_alu_result;

  // Upper address bits are dropped so the byte address wraps inside the array
  assign w_word_idx = i_MEM_alu_result[NB_ADDR+1:2];
  assign w_size     = decode_size(i_MEM_word_en, i_MEM_halfword_en, i_MEM_byte_en);
  // Reset and a held pipeline both suppress the store
  assign w_we       = i_MEM_enable & ~i_reset & i_MEM_mem_write & (w_size != SIZE_NONE);

  // Place store data on every candidate lane and pick lanes with the byte enables
  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    case (w_size)
      SIZE_WORD: begin
        w_be    = '1;
        w_wdata = i_MEM_data_b;
      end
      SIZE_HALF: begin
        w_be    = NB_BE'(2'b11) << {i_MEM_alu_result[1], 1'b0};
        w_wdata = {(NB_DATA/16){i_MEM_data_b[15:0]}};
      end
      SIZE_BYTE: begin
        w_be    = NB_BE'(1'b1) << i_MEM_alu_result[1:0];
        w_wdata = {(NB_DATA/8){i_MEM_data_b[7:0]}};
      end
      default: ;
    endcase
  end

  data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .i_clk        (i_clk),
    .i_we         (w_we),
    .i_addr       (w_word_idx),
    .i_be         (w_be),
    .i_wdata      (w_wdata),
    .o_rdata      (w_rd_word),
    .i_debug_addr (i_MEM_debug_addr),
    .o_debug_data (o_MEM_debug_data)
  );

  // Read side sees the pre-write word, giving read-before-write for a combined access
  assign w_byte = w_rd_word[{i_MEM_alu_result[1:0], 3'b000} +: 8];
  assign w_half = w_rd_word[{i_MEM_alu_result[1], 4'b0000} +: 16];

  // Lane select and sign/zero extension of the load value; no read or no size loads zero
  always_comb begin
    w_load = '0;
    if (i_MEM_mem_read) begin
      case (w_size)
        SIZE_WORD: w_load = w_rd_word;
        SIZE_HALF: w_load = i_MEM_unsigned ? {{(NB_DATA-16){1'b0}}, w_half}
                                           : {{(NB_DATA-16){w_half[15]}}, w_half};
        SIZE_BYTE: w_load = i_MEM_unsigned ? {{(NB_DATA-8){1'b0}}, w_byte}
                                           : {{(NB_DATA-8){w_byte[7]}}, w_byte};
        default:   w_load = '0;
      endcase
    end
  end

  // MEM/WB register; halt flag accumulates until reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_reg_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_r31_ctrl     <= 1'b0;
      r_hlt          <= 1'b0;
      r_mem_data     <= '0;
      r_alu_result   <= '0;
      r_selected_reg <= '0;
      r_pc           <= '0;
    end else if (i_MEM_enable) begin
      r_reg_write    <= i_MEM_reg_write;
      r_mem_to_reg   <= i_MEM_mem_to_reg;
      r_r31_ctrl     <= i_MEM_r31_ctrl;
      r_hlt          <= r_hlt | i_MEM_hlt;
      r_mem_data     <= w_load;
      r_alu_result   <= i_MEM_alu_result;
      r_selected_reg <= i_MEM_selected_reg;
      r_pc           <= i_MEM_pc;
    end
  end

  assign o_WB_reg_write    = r_reg_write;
  assign o_WB_mem_to_reg   = r_mem_to_reg;
  assign o_WB_r31_ctrl     = r_r31_ctrl;
  assign o_WB_hlt          = r_hlt;
  assign o_WB_mem_data     = r_mem_data;
  assign o_WB_alu_result   = r_alu_result;
  assign o_WB_selected_reg = r_selected_reg;
  assign o_WB_pc           = r_pc;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed memory model plus queue scoreboard of MEM/WB results.
// Latency: expects WB outputs one edge after each issued cycle.
// Backpressure: exercises enable-low hold cycles and mid-run resets.
module tb_mem_stage;

  logic        i_clk;
  logic        i_reset;
  logic        i_MEM_enable;
  logic        i_MEM_reg_write, i_MEM_mem_to_reg;
  logic        i_MEM_mem_read, i_MEM_mem_write, i_MEM_branch, i_MEM_zero;
  logic [31:0] i_MEM_branch_addr, i_MEM_alu_result, i_MEM_data_b, i_MEM_pc;
  logic [4:0]  i_MEM_selected_reg;
  logic        i_MEM_byte_en, i_MEM_halfword_en, i_MEM_word_en, i_MEM_unsigned;
  logic        i_MEM_r31_ctrl, i_MEM_hlt;
  logic [7:0]  i_MEM_debug_addr;
  logic        o_MEM_pc_src;
  logic [31:0] o_MEM_branch_addr, o_MEM_fwd_data;
  logic        o_WB_reg_write, o_WB_mem_to_reg, o_WB_r31_ctrl, o_WB_hlt;
  logic [31:0] o_WB_mem_data, o_WB_alu_result, o_WB_pc, o_MEM_debug_data;
  logic [4:0]  o_WB_selected_reg;

  mem_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_MEM_enable(i_MEM_enable),
    .i_MEM_reg_write(i_MEM_reg_write), .i_MEM_mem_to_reg(i_MEM_mem_to_reg),
    .i_MEM_mem_read(i_MEM_mem_read), .i_MEM_mem_write(i_MEM_mem_write),
    .i_MEM_branch(i_MEM_branch), .i_MEM_zero(i_MEM_zero),
    .i_MEM_branch_addr(i_MEM_branch_addr), .i_MEM_alu_result(i_MEM_alu_result),
    .i_MEM_data_b(i_MEM_data_b), .i_MEM_selected_reg(i_MEM_selected_reg),
    .i_MEM_byte_en(i_MEM_byte_en), .i_MEM_halfword_en(i_MEM_halfword_en),
    .i_MEM_word_en(i_MEM_word_en), .i_MEM_unsigned(i_MEM_unsigned),
    .i_MEM_r31_ctrl(i_MEM_r31_ctrl), .i_MEM_pc(i_MEM_pc), .i_MEM_hlt(i_MEM_hlt),
    .i_MEM_debug_addr(i_MEM_debug_addr),
    .o_MEM_pc_src(o_MEM_pc_src), .o_MEM_branch_addr(o_MEM_branch_addr),
    .o_MEM_fwd_data(o_MEM_fwd_data),
    .o_WB_reg_write(o_WB_reg_write), .o_WB_mem_to_reg(o_WB_mem_to_reg),
    .o_WB_r31_ctrl(o_WB_r31_ctrl), .o_WB_hlt(o_WB_hlt),
    .o_WB_mem_data(o_WB_mem_data), .o_WB_alu_result(o_WB_alu_result),
    .o_WB_selected_reg(o_WB_selected_reg), .o_WB_pc(o_WB_pc),
    .o_MEM_debug_data(o_MEM_debug_data)
  );

  typedef struct packed {
    logic        rw, m2r, r31, hlt;
    logic [31:0] md, alu;
    logic [4:0]  sel;
    logic [31:0] pc;
  } wb_t;

  typedef struct {
    bit          rst, en, rw, m2r, rd, wr, br, zr, uns, r31, hlt;
    logic [2:0]  sz;    // {word, half, byte}
    logic [31:0] alu, datab, baddr, pc;
    logic [4:0]  sel;
    logic [7:0]  dbg;
  } stim_t;

  localparam logic [2:0] SZ_W = 3'b100, SZ_H = 3'b010, SZ_B = 3'b001;

  wb_t        exp_q[$];
  wb_t        model_wb;
  logic [7:0] mbytes [0:1023];
  int         n_cmp = 0;
  int         n_err = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    int b;
    b = a & ~3;
    return {mbytes[b+3], mbytes[b+2], mbytes[b+1], mbytes[b]};
  endfunction

  // Load value from the byte model: little-endian, naturally aligned per size
  function automatic logic [31:0] model_load(input stim_t s);
    int a, b;
    logic [15:0] h;
    logic [7:0]  y;
    a = int'(s.alu[9:0]);
    if (!s.rd) return 32'h0;
    if (s.sz[2]) return word_at(a);
    if (s.sz[1]) begin
      b = a & ~1;
      h = {mbytes[b+1], mbytes[b]};
      return s.uns ? {16'h0, h} : {{16{h[15]}}, h};
    end
    if (s.sz[0]) begin
      y = mbytes[a];
      return s.uns ? {24'h0, y} : {{24{y[7]}}, y};
    end
    return 32'h0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    int          a, b;
    logic [31:0] ld;
    @(negedge i_clk);
    i_reset = s.rst; i_MEM_enable = s.en;
    i_MEM_reg_write = s.rw; i_MEM_mem_to_reg = s.m2r;
    i_MEM_mem_read = s.rd; i_MEM_mem_write = s.wr;
    i_MEM_branch = s.br; i_MEM_zero = s.zr;
    i_MEM_branch_addr = s.baddr; i_MEM_alu_result = s.alu; i_MEM_data_b = s.datab;
    i_MEM_selected_reg = s.sel;
    i_MEM_word_en = s.sz[2]; i_MEM_halfword_en = s.sz[1]; i_MEM_byte_en = s.sz[0];
    i_MEM_unsigned = s.uns; i_MEM_r31_ctrl = s.r31; i_MEM_pc = s.pc; i_MEM_hlt = s.hlt;
    i_MEM_debug_addr = s.dbg;
    #1;
    chk("pc_src", {31'h0, o_MEM_pc_src}, {31'h0, s.br & s.zr});
    chk("branch_addr", o_MEM_branch_addr, s.baddr);
    chk("fwd_data", o_MEM_fwd_data, s.alu);
    chk("debug_data", o_MEM_debug_data, word_at(int'(s.dbg) * 4));
    ld = model_load(s);
    if (s.rst) model_wb = '0;
    else if (s.en) begin
      model_wb.rw  = s.rw;   model_wb.m2r = s.m2r; model_wb.r31 = s.r31;
      model_wb.hlt = model_wb.hlt | s.hlt;
      model_wb.md  = ld;     model_wb.alu = s.alu;
      model_wb.sel = s.sel;  model_wb.pc  = s.pc;
    end
    exp_q.push_back(model_wb);
    if (!s.rst && s.en && s.wr) begin
      a = int'(s.alu[9:0]);
      if (s.sz[2]) begin
        b = a & ~3;
        for (int k = 0; k < 4; k++) mbytes[b+k] = s.datab[8*k +: 8];
      end else if (s.sz[1]) begin
        b = a & ~1;
        mbytes[b] = s.datab[7:0]; mbytes[b+1] = s.datab[15:8];
      end else if (s.sz[0]) begin
        mbytes[a] = s.datab[7:0];
      end
    end
  endtask

  task automatic st(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] d);
    stim_t s;
    s = idle(); s.en = 1; s.wr = 1; s.sz = sz; s.alu = addr; s.datab = d;
    s.pc = $urandom; s.dbg = addr[9:2];
    drive(s);
  endtask

  // Issue a load and check the registered result against a literal one edge later
  task automatic ld_chk(input string nm, input logic [2:0] sz, input logic [31:0] addr,
                        input bit uns, input logic [31:0] exp);
    stim_t s;
    s = idle(); s.en = 1; s.rd = 1; s.m2r = 1; s.rw = 1; s.sz = sz; s.uns = uns;
    s.alu = addr; s.sel = 5'd7; s.pc = 32'h400;
    drive(s);
    @(posedge i_clk);
    #2;
    chk(nm, o_WB_mem_data, exp);
  endtask

  task automatic dbg_chk(input string nm, input logic [7:0] wi, input logic [31:0] exp);
    stim_t s;
    s = idle(); s.dbg = wi;
    drive(s);
    chk(nm, o_MEM_debug_data, exp);
  endtask

  // Monitor: every edge after issued stimulus yields one MEM/WB result to compare
  initial begin
    wb_t e, a;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.rw = o_WB_reg_write; a.m2r = o_WB_mem_to_reg; a.r31 = o_WB_r31_ctrl;
        a.hlt = o_WB_hlt; a.md = o_WB_mem_data; a.alu = o_WB_alu_result;
        a.sel = o_WB_selected_reg; a.pc = o_WB_pc;
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL wb_regs: got %h expected %h", a, e);
        end
      end
    end
  end

  initial begin
    stim_t s;
    i_reset = 1; i_MEM_enable = 0; i_MEM_reg_write = 0; i_MEM_mem_to_reg = 0;
    i_MEM_mem_read = 0; i_MEM_mem_write = 0; i_MEM_branch = 0; i_MEM_zero = 0;
    i_MEM_branch_addr = 0; i_MEM_alu_result = 0; i_MEM_data_b = 0; i_MEM_pc = 0;
    i_MEM_selected_reg = 0; i_MEM_byte_en = 0; i_MEM_halfword_en = 0; i_MEM_word_en = 0;
    i_MEM_unsigned = 0; i_MEM_r31_ctrl = 0; i_MEM_hlt = 0; i_MEM_debug_addr = 0;
    model_wb = '0;
    for (int i = 0; i < 1024; i++) mbytes[i] = 8'h00;

    // Reset with busy inputs: WB must read zero
    s = idle(); s.rst = 1; s.en = 1; s.rw = 1; s.hlt = 1; s.alu = 32'h55; s.pc = 32'h99;
    drive(s);
    drive(s);
    chk("reset_wb_pc", o_WB_pc, 32'h0);

    // Give every word a defined value
    for (int i = 0; i < 256; i++) st(SZ_W, i * 4, $urandom);

    st(SZ_W, 32'h10, 32'hDEADBEEF);
    ld_chk("word_load_0x10", SZ_W, 32'h10, 0, 32'hDEADBEEF);
    st(SZ_B, 32'h11, 32'h0000007F);
    dbg_chk("byte_store_word", 8'h04, 32'hDEAD7FEF);
    ld_chk("lb_0x13", SZ_B, 32'h13, 0, 32'hFFFFFFDE);
    ld_chk("lbu_0x13", SZ_B, 32'h13, 1, 32'h000000DE);
    ld_chk("lh_0x12", SZ_H, 32'h12, 0, 32'hFFFFDEAD);
    st(SZ_H, 32'h10, 32'h00001234);
    dbg_chk("half_store_word", 8'h04, 32'hDEAD1234);
    // Address wrap: 0x410 aliases 0x10
    ld_chk("wrap_load", SZ_W, 32'h0000_0410, 0, 32'hDEAD1234);
    // Read and write together returns the old word
    s = idle(); s.en = 1; s.rd = 1; s.wr = 1; s.sz = SZ_W; s.alu = 32'h10; s.datab = 32'hCAFEF00D;
    drive(s);
    @(posedge i_clk); #2;
    chk("rbw_load", o_WB_mem_data, 32'hDEAD1234);
    dbg_chk("rbw_written", 8'h04, 32'hCAFEF00D);
    // Size priority: word beats byte
    s = idle(); s.en = 1; s.wr = 1; s.sz = 3'b111; s.alu = 32'h10; s.datab = 32'h11223344;
    drive(s);
    dbg_chk("prio_word", 8'h04, 32'h11223344);
    // Write with no size enable changes nothing
    s = idle(); s.en = 1; s.wr = 1; s.sz = 3'b000; s.alu = 32'h10; s.datab = 32'h0;
    drive(s);
    dbg_chk("no_size_write", 8'h04, 32'h11223344);

    // Branch resolve
    s = idle(); s.en = 1; s.br = 1; s.zr = 1; s.baddr = 32'h1234_5678;
    drive(s);
    chk("pc_src_taken", {31'h0, o_MEM_pc_src}, 32'h1);
    s.zr = 0;
    drive(s);
    chk("pc_src_not_taken", {31'h0, o_MEM_pc_src}, 32'h0);

    // Hold: load a known WB state, then enable low with a store
    s = idle(); s.en = 1; s.rw = 1; s.alu = 32'hA5A5_0000; s.pc = 32'h0000_0ABC; s.sel = 5'd9;
    drive(s);
    s = idle(); s.en = 0; s.wr = 1; s.sz = SZ_W; s.alu = 32'h10; s.datab = 32'h0; s.pc = 32'h1;
    drive(s);
    @(posedge i_clk); #2;
    chk("hold_pc", o_WB_pc, 32'h0000_0ABC);
    dbg_chk("hold_no_store", 8'h04, 32'h11223344);
    // Reset with a store presented
    s.rst = 1; s.en = 1;
    drive(s);
    dbg_chk("reset_no_store", 8'h04, 32'h11223344);

    // Sticky halt
    s = idle(); s.en = 1; s.hlt = 1;
    drive(s);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.en = (i != 1); s.pc = $urandom;
      drive(s);
    end
    @(posedge i_clk); #2;
    chk("hlt_sticky", {31'h0, o_WB_hlt}, 32'h1);
    s = idle(); s.rst = 1;
    drive(s);
    @(posedge i_clk); #2;
    chk("hlt_cleared", {31'h0, o_WB_hlt}, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s.rst   = ($urandom_range(0, 49) == 0);
      s.en    = ($urandom_range(0, 9) != 0);
      s.rw    = $urandom_range(0, 1); s.m2r = $urandom_range(0, 1);
      s.rd    = $urandom_range(0, 1); s.wr  = $urandom_range(0, 1);
      s.br    = $urandom_range(0, 1); s.zr  = $urandom_range(0, 1);
      s.uns   = $urandom_range(0, 1); s.r31 = $urandom_range(0, 1);
      s.hlt   = ($urandom_range(0, 29) == 0);
      s.sz    = 3'($urandom_range(0, 7));
      s.alu   = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h3F);
      s.datab = $urandom; s.baddr = $urandom; s.pc = $urandom;
      s.sel   = 5'($urandom); s.dbg = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h0;
      drive(s);
    end

    repeat (3) @(posedge i_clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters SHALL be: NB_DATA, default 32, data/address width; NB_PC, default 32, PC width; NB_REG, default 5, register index width; NB_ADDR, default 8, data memory word-index width (256 words).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
 i_clk  in  1  single clock, rising edge
 i_reset  in  1  synchronous, active-high reset
 i_MEM_enable  in  1  step enable from debug unit; low = hold
 i_MEM_reg_write, i_MEM_mem_to_reg  in  1  WB flags from EX
 i_MEM_mem_read, i_MEM_mem_write, i_MEM_branch  in  1  MEM flags from EX
 i_MEM_zero  in  1  ALU zero
 i_MEM_branch_addr  in  NB_PC  branch target
 i_MEM_alu_result  in  NB_DATA  ALU result / byte address
 i_MEM_data_b  in  NB_DATA  store data
 i_MEM_selected_reg  in  NB_REG  destination register
 i_MEM_byte_en, i_MEM_halfword_en, i_MEM_word_en  in  1  access size
 i_MEM_unsigned  in  1  zero-extend loads (LBU/LHU)
 i_MEM_r31_ctrl  in  1  link-register write
 i_MEM_pc  in  NB_PC  PC of instruction
 i_MEM_hlt  in  1  halt instruction
 i_MEM_debug_addr  in  NB_ADDR  debug word index
 o_MEM_pc_src  out  1  take branch
 o_MEM_branch_addr  out  NB_PC  branch target
 o_MEM_fwd_data  out  NB_DATA  forwarding data to EX
 o_WB_reg_write, o_WB_mem_to_reg, o_WB_r31_ctrl, o_WB_hlt  out  1  registered flags
 o_WB_mem_data  out  NB_DATA  registered load data
 o_WB_alu_result  out  NB_DATA  registered ALU result
 o_WB_selected_reg  out  NB_REG  registered destination
 o_WB_pc  out  NB_PC  registered PC
 o_MEM_debug_data  out  NB_DATA  debug read data
REQ-003 Clock and reset SHALL be i_clk and i_reset; one clock, reset synchronous and active-high.

Function
REQ-004 o_MEM_pc_src SHALL equal i_MEM_branch AND i_MEM_zero, combinationally; o_MEM_branch_addr and o_MEM_fwd_data SHALL pass i_MEM_branch_addr and i_MEM_alu_result through combinationally.
REQ-005 Word index SHALL be i_MEM_alu_result[NB_ADDR+1:2]; higher bits ignored (address wraps modulo 1 KiB).
REQ-006 Size priority SHALL be word > halfword > byte; mem_write/mem_read with no size enable SHALL do no write and load zero.
REQ-007 Store (mem_write=1, enable=1) SHALL commit at the rising edge: byte writes data_b[7:0] into lane alu_result[1:0]; halfword writes data_b[15:0] into half alu_result[1]; word writes all 32 bits; unselected lanes preserved.
REQ-008 Load data SHALL be read combinationally from the current array, lane-selected as in REQ-007, sign-extended unless i_MEM_unsigned=1, then registered to o_WB_mem_data.
REQ-009 mem_read and mem_write together SHALL return the pre-write word (read-before-write).
REQ-010 MEM/WB register: with i_MEM_enable=1, every o_WB_* output SHALL capture its i_MEM_* source at the rising edge (latency 1 cycle); with i_MEM_enable=0, outputs hold and no store commits.
REQ-011 o_WB_hlt SHALL be sticky: once captured as 1 it stays 1 until reset, regardless of i_MEM_hlt.
REQ-012 o_MEM_debug_data SHALL be the word at i_MEM_debug_addr, combinational, reflecting stores from previous edges only.

Reset
REQ-013 With i_reset=1 at an edge, all o_WB_* outputs SHALL become 0 and no store commits, even if mem_write=1 and enable=1.
REQ-014 Memory array contents SHALL NOT be reset.

Structure
REQ-015 Size-encoding constants and NB_ADDR default SHALL live in the shared pipeline package.
REQ-016 One sub-module data_memory (array, byte-lane write, read and debug ports) SHALL be instantiated; lane select/extension and MEM/WB register in mem_stage.

Verification
REQ-017 Word store 0xDEADBEEF to addr 0x10, then word load 0x10 -> o_WB_mem_data=0xDEADBEEF one cycle after load presented.
REQ-018 Byte store 0x7F to addr 0x11 over 0xDEADBEEF -> word reads 0xDEAD7FEF; byte load 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-019 Halfword load addr 0x12 of 0xDEAD7FEF, signed -> 0xFFFFDEAD; store halfword 0x1234 at 0x10 -> 0xDEAD1234.
REQ-020 branch=1, zero=1 -> o_MEM_pc_src=1 same cycle; branch=1, zero=0 -> 0.
REQ-021 enable=0 with mem_write=1 -> memory unchanged, o_WB_* hold; reset with mem_write=1 -> outputs 0, memory unchanged.
REQ-022 hlt=1 for one cycle then 0 -> o_WB_hlt stays 1 until i_reset.
